uart_tx_scheduler: RTL

- Round-robin scheduler that shares the single SECDED-encoding UART transmit path (uart_tx_wrapper) between NREQ requesters.
- Latches the winning requester's word and frame config, then sequences the wrapper through load, start, frame and completion.
- Guards the clear-to-send wait with a timeout and reports per-requester ack/err pulses.
- Sits between the controller's requesters and the wrapper's tx_ena/tx_loaded/tx_config/tx_word/status/rx_rts interface.

---
 rtl/uart_tx_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one SECDED UART transmit wrapper between
// NREQ requesters. Latches the winner's word/config, sequences the wrapper
// through load/start/frame/completion, and aborts on a clear-to-send timeout
// or on enable dropping. All outputs are registered.
module uart_tx_scheduler #(
    parameter int NREQ        = 4,
    parameter int CTS_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*10-1:0] req_word,
    input  logic [NREQ*5-1:0]  req_config,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    err,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic [15:0]        frames_sent,
    input  logic [1:0]         tx_status,
    input  logic               rx_rts,
    output logic               tx_ena,
    output logic               tx_loaded,
    output logic [4:0]         tx_config,
    output logic [9:0]         tx_word
);

    localparam int CW = (CTS_TIMEOUT > 2) ? $clog2(CTS_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_START,
        S_BUSY,
        S_DONE,
        S_ABORT
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            seen_stop, seen_nx;
    logic [2:0]      ptr;
    logic [2:0]      win;
    logic            found;
    logic [NREQ-1:0] grant_onehot;

    // rx_rts only matters to the wrapper; the timeout is a plain cycle bound.
    logic unused_rx_rts;
    assign unused_rx_rts = rx_rts;

    assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;

    // Pick the first requester at or after ptr+1, wrapping modulo NREQ.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    // Next-state, timeout counter and stop-seen tracking.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        seen_nx  = seen_stop;
        case (state)
            S_IDLE: begin
                if (enable && found) state_nx = S_LOAD;
            end
            S_LOAD: begin
                cnt_nx   = '0;
                seen_nx  = 1'b0;
                state_nx = enable ? S_WAIT_START : S_ABORT;
            end
            S_WAIT_START: begin
                if (!enable)                           state_nx = S_ABORT;
                else if (tx_status != 2'd0)            state_nx = S_BUSY;
                else if (cnt == CW'(CTS_TIMEOUT - 1))  state_nx = S_ABORT;
                else                                   cnt_nx   = cnt + CW'(1);
            end
            S_BUSY: begin
                if (!enable) begin
                    state_nx = S_ABORT;
                end else begin
                    if (tx_status == 2'd3) seen_nx = 1'b1;
                    // Completion needs a STOP seen earlier, then IDLE status.
                    if (seen_stop && tx_status == 2'd0) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                seen_nx  = 1'b0;
                state_nx = S_IDLE;
            end
            S_ABORT: begin
                seen_nx  = 1'b0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register and registered outputs, aligned with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            seen_stop   <= 1'b0;
            ptr         <= 3'(NREQ - 1);
            grant_id    <= 3'(NREQ - 1);
            ack         <= '0;
            err         <= '0;
            busy        <= 1'b0;
            frames_sent <= '0;
            tx_ena      <= 1'b0;
            tx_loaded   <= 1'b0;
            tx_config   <= '0;
            tx_word     <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            seen_stop <= seen_nx;
            tx_ena    <= enable && (state_nx != S_ABORT);
            tx_loaded <= (state_nx == S_LOAD);
            busy      <= (state_nx != S_IDLE);
            ack       <= '0;
            err       <= '0;
            // Word/config stay frozen from grant until the next grant.
            if (state == S_IDLE && state_nx == S_LOAD) begin
                grant_id  <= win;
                tx_word   <= req_word[win*10 +: 10];
                tx_config <= req_config[win*5 +: 5];
            end
            if (state_nx == S_DONE) begin
                ack         <= grant_onehot;
                frames_sent <= frames_sent + 16'd1;
                ptr         <= grant_id;
            end
            if (state_nx == S_ABORT) begin
                err <= grant_onehot;
                ptr <= grant_id;
            end
        end
    end

endmodule
